// File: rtl/multicycle_control.sv
// Multicycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencer driving datapath control.
// Optional retired-instruction counter enabled by defining CTRL_PERF_EN.
module multicycle_control #(
  parameter int unsigned FETCH_TIMEOUT = 16,
  parameter logic [3:0]  ALU_AND       = 4'b0000,
  parameter logic [3:0]  ALU_OR        = 4'b0001,
  parameter logic [3:0]  ALU_ADD       = 4'b0010,
  parameter logic [3:0]  ALU_SUB       = 4'b0110,
  parameter logic [3:0]  ALU_SLT       = 4'b0111
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        run,
  output logic        fetch_req,
  input  logic        instr_valid,
  input  logic [3:0]  opcode,
  input  logic        Zero,
  output logic [3:0]  ALUctl,
  output logic        ALUSrc,
  output logic        MemtoReg,
  output logic        Regwrite,
  output logic        wr_en,
  output logic        PCSrc,
  output logic        pc_wr,
  output logic        halted,
  output logic        trap,
  output logic [31:0] instr_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;
  localparam logic [2:0] S_TRAP   = 3'd7;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_SLT  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LW   = 4'h6;
  localparam logic [3:0] OP_SW   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  logic [2:0]  state, state_nxt, retire_nxt;
  logic [3:0]  op_q, alu_op;
  logic [31:0] wait_cnt;
  logic        is_imm, illegal, timeout;

  assign is_imm     = (op_q == OP_ADDI) || (op_q == OP_LW) || (op_q == OP_SW);
  assign illegal    = (op_q >= 4'h9) && (op_q <= 4'hE);
  assign timeout    = (FETCH_TIMEOUT != 0) && (wait_cnt == 32'(FETCH_TIMEOUT - 1));
  assign retire_nxt = run ? S_FETCH : S_IDLE;

  always_comb begin
    case (op_q)
      OP_ADD, OP_ADDI, OP_LW, OP_SW: alu_op = ALU_ADD;
      OP_SUB, OP_BEQ:                alu_op = ALU_SUB;
      OP_AND:                        alu_op = ALU_AND;
      OP_OR:                         alu_op = ALU_OR;
      OP_SLT:                        alu_op = ALU_SLT;
      default:                       alu_op = 4'h0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (run) state_nxt = S_FETCH;
      // a transfer on the timeout cycle takes priority over trapping
      S_FETCH:  if (instr_valid) state_nxt = S_DECODE;
                else if (timeout) state_nxt = S_TRAP;
      S_DECODE: if (op_q == OP_HALT) state_nxt = S_HALT;
                else if (illegal)    state_nxt = S_TRAP;
                else                 state_nxt = S_EXEC;
      S_EXEC:   if (op_q == OP_BEQ) state_nxt = retire_nxt;
                else if ((op_q == OP_LW) || (op_q == OP_SW)) state_nxt = S_MEM;
                else state_nxt = S_WB;
      S_MEM:    state_nxt = (op_q == OP_SW) ? retire_nxt : S_WB;
      S_WB:     state_nxt = retire_nxt;
      default:  state_nxt = state;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      op_q     <= 4'h0;
      wait_cnt <= 32'h0;
    end else begin
      state <= state_nxt;
      if ((state == S_FETCH) && instr_valid) op_q <= opcode;
      // counts consecutive wait cycles; zero whenever FETCH is (re)entered
      wait_cnt <= ((state == S_FETCH) && !instr_valid) ? wait_cnt + 32'h1 : 32'h0;
    end
  end

  always_comb begin
    fetch_req = 1'b0;
    ALUctl    = 4'h0;
    ALUSrc    = 1'b0;
    MemtoReg  = 1'b0;
    Regwrite  = 1'b0;
    wr_en     = 1'b0;
    PCSrc     = 1'b0;
    pc_wr     = 1'b0;
    halted    = 1'b0;
    trap      = 1'b0;
    case (state)
      S_FETCH: fetch_req = 1'b1;
      S_EXEC: begin
        ALUctl = alu_op;
        ALUSrc = is_imm;
        if (op_q == OP_BEQ) begin
          PCSrc = Zero;
          pc_wr = 1'b1;
        end
      end
      S_MEM: begin
        ALUctl = alu_op;
        ALUSrc = is_imm;
        if (op_q == OP_SW) begin
          wr_en = 1'b1;
          pc_wr = 1'b1;
        end
      end
      S_WB: begin
        ALUctl   = alu_op;
        ALUSrc   = is_imm;
        Regwrite = 1'b1;
        MemtoReg = (op_q == OP_LW);
        pc_wr    = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      S_TRAP:  trap   = 1'b1;
      default: ;
    endcase
    // an instruction caught by reset must not commit anything
    if (!reset_n) begin
      wr_en    = 1'b0;
      Regwrite = 1'b0;
      pc_wr    = 1'b0;
    end
  end

`ifdef CTRL_PERF_EN
  logic [31:0] instr_count_q;

  always_ff @(posedge clock) begin
    if (!reset_n)   instr_count_q <= 32'h0;
    else if (pc_wr) instr_count_q <= instr_count_q + 32'h1;
  end

  assign instr_count = instr_count_q;
`else
  assign instr_count = 32'h0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control against a per-instruction
// timing model (latency table + which strobes fire on the retire cycle).
module tb_multicycle_control;
  localparam int unsigned TO = 4;

  logic        clock = 1'b0;
  logic        reset_n, run, instr_valid, Zero;
  logic [3:0]  opcode;
  logic        fetch_req, ALUSrc, MemtoReg, Regwrite, wr_en, PCSrc, pc_wr, halted, trap;
  logic [3:0]  ALUctl;
  logic [31:0] instr_count;
  logic [12:0] outs;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_count = 32'h0;

  localparam logic [12:0] V_FETCH = 13'h1000;
  localparam logic [12:0] V_HALT  = 13'h0002;
  localparam logic [12:0] V_TRAP  = 13'h0001;

  multicycle_control #(.FETCH_TIMEOUT(TO)) dut (
    .clock(clock), .reset_n(reset_n), .run(run), .fetch_req(fetch_req),
    .instr_valid(instr_valid), .opcode(opcode), .Zero(Zero), .ALUctl(ALUctl),
    .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .Regwrite(Regwrite), .wr_en(wr_en),
    .PCSrc(PCSrc), .pc_wr(pc_wr), .halted(halted), .trap(trap), .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  assign outs = {fetch_req, ALUctl, ALUSrc, MemtoReg, Regwrite, wr_en, PCSrc, pc_wr, halted, trap};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: cycle 1 is the fetch transfer, 2 is decode, 3.. executes;
  // every write strobe and the PC update land on the last (retire) cycle.
  function automatic int lat(input logic [3:0] op);
    if (op == 4'h8) return 3;
    if (op == 4'h6) return 5;
    return 4;
  endfunction

  function automatic logic [3:0] alu_of(input logic [3:0] op);
    case (op)
      4'h1, 4'h8: return 4'b0110;
      4'h2:       return 4'b0000;
      4'h3:       return 4'b0001;
      4'h4:       return 4'b0111;
      default:    return 4'b0010;
    endcase
  endfunction

  function automatic logic [12:0] exp_vec(input logic [3:0] op, input logic z, input int c);
    logic last;
    last = (c == lat(op));
    if (c == 1) return V_FETCH;
    if (c == 2) return 13'h0;
    return {1'b0, alu_of(op), (op >= 4'h5 && op <= 4'h7), last && (op == 4'h6),
            last && (op <= 4'h6), last && (op == 4'h7), last && (op == 4'h8) && z,
            last, 1'b0, 1'b0};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_cyc(input string tag, input logic [12:0] exp);
    @(negedge clock);
    chk(tag, {19'h0, outs}, {19'h0, exp});
    tick();
  endtask

  task automatic chk_count(input string tag);
`ifdef CTRL_PERF_EN
    chk(tag, instr_count, exp_count);
`else
    chk(tag, instr_count, 32'h0);
`endif
  endtask

  task automatic do_reset();
    reset_n = 1'b0; run = 1'b0; instr_valid = 1'b0;
    opcode = 4'($urandom); Zero = 1'($urandom);
    tick();
    tick();
    reset_n = 1'b1;
    exp_count = 32'h0;
    chk_count("reset_count");
    chk_cyc("reset_outs", 13'h0);
  endtask

  task automatic start();
    run = 1'b1;
    chk_cyc("idle_run", 13'h0);
  endtask

  // Runs one legal instruction from FETCH; zmode<0 randomizes Zero every cycle.
  task automatic run_instr(input logic [3:0] op, input int waits, input logic last_run,
                           input int zmode);
    logic z;
    chk_count($sformatf("count_before_op%0h", op));
    for (int w = 0; w < waits; w++) begin
      instr_valid = 1'b0; opcode = 4'($urandom); Zero = 1'($urandom); run = 1'($urandom);
      chk_cyc("fetch_wait", V_FETCH);
    end
    instr_valid = 1'b1; opcode = op; Zero = 1'($urandom); run = 1'($urandom);
    chk_cyc($sformatf("op%0h_c1", op), exp_vec(op, 1'b0, 1));
    for (int c = 2; c <= lat(op); c++) begin
      z = (zmode < 0) ? 1'($urandom) : 1'(zmode);
      instr_valid = 1'($urandom); opcode = 4'($urandom); Zero = z;
      run = (c == lat(op)) ? last_run : 1'($urandom);
      chk_cyc($sformatf("op%0h_c%0d", op, c), exp_vec(op, z, c));
    end
    instr_valid = 1'b0;
    exp_count++;
    if (!last_run) begin
      run = 1'b0;
      chk_cyc("idle_hold", 13'h0);
      run = 1'b1;
      chk_cyc("idle_go", 13'h0);
    end
  endtask

  task automatic sticky(input string tag, input logic [12:0] exp, input int n);
    for (int i = 0; i < n; i++) begin
      run = 1'($urandom); instr_valid = 1'($urandom); opcode = 4'($urandom); Zero = 1'($urandom);
      chk_cyc(tag, exp);
    end
    chk_count({tag, "_count"});
  endtask

  task automatic run_stop(input logic [3:0] op, input logic [12:0] exp);
    instr_valid = 1'b1; opcode = op;
    chk_cyc("stop_fetch", V_FETCH);
    instr_valid = 1'b0; opcode = 4'($urandom);
    chk_cyc("stop_decode", 13'h0);
    sticky($sformatf("stop_op%0h", op), exp, 4);
  endtask

  initial begin
    do_reset();
    start();

    // directed: ADD, LW then SW, BEQ taken/not taken, transfer on timeout cycle
    run_instr(4'h0, 0, 1'b1, -1);
    run_instr(4'h6, 0, 1'b1, -1);
    run_instr(4'h7, 0, 1'b1, -1);
    run_instr(4'h8, 0, 1'b1, 1);
    run_instr(4'h8, 0, 1'b1, 0);
    run_instr(4'h5, int'(TO) - 1, 1'b1, -1);

    for (int i = 0; i < 40; i++)
      run_instr(4'($urandom_range(0, 8)), int'($urandom_range(0, TO - 1)),
                1'($urandom_range(0, 3) != 0), -1);

    // illegal opcodes, HALT, fetch timeout
    do_reset(); start();
    run_stop(4'hA, V_TRAP);
    do_reset(); start();
    run_instr(4'h1, 0, 1'b1, -1);
    run_stop(4'($urandom_range(9, 14)), V_TRAP);
    do_reset(); start();
    run_stop(4'hF, V_HALT);
    do_reset(); start();
    for (int i = 0; i < int'(TO); i++) begin
      instr_valid = 1'b0;
      chk_cyc("timeout_fetch", V_FETCH);
    end
    sticky("timeout_trap", V_TRAP, 3);

    // reset arriving in the WB cycle of a LW
    do_reset(); start();
    instr_valid = 1'b1; opcode = 4'h6;
    chk_cyc("rst_lw_fetch", V_FETCH);
    instr_valid = 1'b0;
    chk_cyc("rst_lw_dec", 13'h0);
    chk_cyc("rst_lw_exec", exp_vec(4'h6, 1'b0, 3));
    chk_cyc("rst_lw_mem", exp_vec(4'h6, 1'b0, 4));
    reset_n = 1'b0;
    chk_cyc("rst_lw_wb", {1'b0, 4'b0010, 1'b1, 1'b1, 6'b0});
    chk_cyc("rst_lw_idle", 13'h0);
    reset_n = 1'b1; run = 1'b0;
    exp_count = 32'h0;
    chk_count("rst_lw_count");
    chk_cyc("rst_lw_after", 13'h0);

`ifdef CTRL_PERF_EN
    // counter wrap from a preloaded value
    start();
    dut.instr_count_q = 32'hFFFF_FFFE;
    exp_count = 32'hFFFF_FFFE;
    run_instr(4'h2, 0, 1'b1, -1);
    run_instr(4'h3, 0, 1'b1, -1);
    chk_count("wrap_count");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
